debounce_multi: RTL and testbench

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

---
 rtl/debounce_multi.sv | 97 +++++++++
 tb/tb_debounce_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: 2-flop synchroniser, per-channel stable counter,
// registered press/release pulses, press-toggled level and optional long-press pulse.
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int LONG_CYCLES   = 0,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_toggle,
  output logic [N_CH-1:0] btn_long
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int LW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam logic [SW-1:0]   STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0]   LONG_MAX    = LW'(LONG_CYCLES);
  localparam logic [N_CH-1:0] RAW_IDLE    = {N_CH{ACTIVE_LOW}};

  logic [N_CH-1:0]         sync1_q, sync1_d;
  logic [N_CH-1:0]         sync2_q, sync2_d;
  logic [N_CH-1:0]         level_q, level_d;
  logic [N_CH-1:0]         press_q, press_d;
  logic [N_CH-1:0]         release_q, release_d;
  logic [N_CH-1:0]         toggle_q, toggle_d;
  logic [N_CH-1:0]         long_q, long_d;
  logic [N_CH-1:0][SW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][LW-1:0] lcnt_q, lcnt_d;
  logic [N_CH-1:0]         samp;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    samp    = sync2_q ^ RAW_IDLE;
    level_d = level_q;
    cnt_d   = '0;
    lcnt_d  = '0;
    long_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      // any sample equal to the current level leaves cnt_d at 0, restarting qualification
      if (samp[i] != level_q[i]) begin
        if (cnt_q[i] == STABLE_LAST) begin
          level_d[i] = samp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (LONG_CYCLES > 0 && level_q[i]) begin
        if (lcnt_q[i] == LONG_MAX) begin
          lcnt_d[i] = lcnt_q[i];
        end else begin
          lcnt_d[i] = lcnt_q[i] + 1'b1;
          long_d[i] = (lcnt_q[i] == LONG_MAX - 1'b1);
        end
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    toggle_d  = toggle_q ^ press_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= RAW_IDLE;
      sync2_q   <= RAW_IDLE;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
      long_q    <= '0;
      cnt_q     <= '0;
      lcnt_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      long_q    <= long_d;
      cnt_q     <= cnt_d;
      lcnt_q    <= lcnt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_toggle  = toggle_q;
  assign btn_long    = long_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: an active-high and an active-low build checked every cycle
// against a window-based model, plus directed scenarios with literal expectations.
module tb_debounce_multi;

  localparam int NC = 2;
  localparam int SC = 4;
  localparam int LC = 10;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] btn_in, btn_in_al;
  logic [NC-1:0] lvl, prs, rel, tgl, lng;
  logic [NC-1:0] lvl_al, prs_al, rel_al, tgl_al, lng_al;

  debounce_multi #(.N_CH(NC), .STABLE_CYCLES(SC), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_toggle(tgl), .btn_long(lng)
  );

  debounce_multi #(.N_CH(NC), .STABLE_CYCLES(SC), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in_al),
    .btn_level(lvl_al), .btn_press(prs_al), .btn_release(rel_al), .btn_toggle(tgl_al),
    .btn_long(lng_al)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks;
  int n_fail;
  int cyc;
  int press0_cnt, rel0_cnt, rel1_cnt, long1_cnt, press1_cyc, long1_cyc;

  // Model, index 0 = active-high build, 1 = active-low build; samples are "pressed" polarity.
  logic [NC-1:0] m_r1[2], m_r2[2];
  logic [NC-1:0] m_lvl[2], m_prs[2], m_rel[2], m_tgl[2], m_lng[2];
  bit            m_win[2][NC][SC];
  int            m_held[2][NC];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_r1[d] = '0; m_r2[d] = '0; m_lvl[d] = '0; m_prs[d] = '0;
      m_rel[d] = '0; m_tgl[d] = '0; m_lng[d] = '0;
      for (int c = 0; c < NC; c++) begin
        m_held[d][c] = 0;
        for (int k = 0; k < SC; k++) m_win[d][c][k] = 1'b0;
      end
    end
  endtask

  // Level flips when the last SC synchronised samples all differ from it.
  task automatic model_update();
    bit s, diff;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        s = m_r2[d][c];
        for (int k = SC - 1; k > 0; k--) m_win[d][c][k] = m_win[d][c][k-1];
        m_win[d][c][0] = s;
        diff = 1'b1;
        for (int k = 0; k < SC; k++) if (m_win[d][c][k] == m_lvl[d][c]) diff = 1'b0;
        m_prs[d][c] = 1'b0;
        m_rel[d][c] = 1'b0;
        m_lng[d][c] = 1'b0;
        if (m_lvl[d][c]) begin
          m_held[d][c]++;
          m_lng[d][c] = (m_held[d][c] == LC);
        end else begin
          m_held[d][c] = 0;
        end
        if (diff) begin
          if (m_lvl[d][c]) m_rel[d][c] = 1'b1;
          else begin
            m_prs[d][c] = 1'b1;
            m_tgl[d][c] = ~m_tgl[d][c];
          end
          m_lvl[d][c] = ~m_lvl[d][c];
        end
      end
      m_r2[d] = m_r1[d];
    end
    m_r1[0] = btn_in;
    m_r1[1] = ~btn_in_al;
  endtask

  task automatic cmp_all();
    cmp("level",      32'(lvl),    32'(m_lvl[0]));
    cmp("press",      32'(prs),    32'(m_prs[0]));
    cmp("release",    32'(rel),    32'(m_rel[0]));
    cmp("toggle",     32'(tgl),    32'(m_tgl[0]));
    cmp("long",       32'(lng),    32'(m_lng[0]));
    cmp("al_level",   32'(lvl_al), 32'(m_lvl[1]));
    cmp("al_press",   32'(prs_al), 32'(m_prs[1]));
    cmp("al_release", 32'(rel_al), 32'(m_rel[1]));
    cmp("al_toggle",  32'(tgl_al), 32'(m_tgl[1]));
    cmp("al_long",    32'(lng_al), 32'(m_lng[1]));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_update();
      @(negedge clk);
      cmp_all();
      if (prs[0]) press0_cnt++;
      if (rel[0]) rel0_cnt++;
      if (prs[1]) press1_cyc = cyc;
      if (rel[1]) rel1_cnt++;
      if (lng[1]) begin
        long1_cnt++;
        long1_cyc = cyc;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    logic [2:0] tgl_exp;
    int c0;
    n_checks = 0; n_fail = 0; cyc = 0;
    press0_cnt = 0; rel0_cnt = 0; rel1_cnt = 0; long1_cnt = 0;
    press1_cyc = -1; long1_cyc = -1;
    rst_n = 1'b0;
    btn_in = '0;
    btn_in_al = '1;
    model_reset();
    step(3);
    cmp("rst_level", 32'(lvl), 32'd0);
    cmp("rst_toggle", 32'(tgl), 32'd0);
    cmp("rst_al_level", 32'(lvl_al), 32'd0);
    cmp("rst_al_press", 32'(prs_al), 32'd0);
    rst_n = 1'b1;
    step(3);

    // clean press on channel 0 of both builds
    btn_in[0] = 1'b1;
    btn_in_al[0] = 1'b0;
    step(5);
    cmp("clean_level_e4", 32'(lvl), 32'd0);
    step(1);
    cmp("clean_level_e5", 32'(lvl), 32'h1);
    cmp("clean_press_e5", 32'(prs), 32'h1);
    cmp("clean_toggle", 32'(tgl), 32'h1);
    cmp("al_level_e5", 32'(lvl_al), 32'h1);
    step(1);
    cmp("clean_press_gone", 32'(prs), 32'd0);
    btn_in = '0;
    btn_in_al = '1;
    step(6);
    cmp("clean_release", 32'(rel), 32'h1);
    step(3);

    // bounce: 2-cycle toggles for 20 cycles, then hold pressed
    press0_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      btn_in[0] = ~btn_in[0];
      step(2);
    end
    cmp("bounce_no_level", 32'(lvl), 32'd0);
    btn_in[0] = 1'b1;
    step(5);
    cmp("bounce_level_e4", 32'(lvl), 32'd0);
    step(1);
    cmp("bounce_level_e5", 32'(lvl), 32'h1);
    step(4);
    cmp("bounce_press_count", 32'(press0_cnt), 32'd1);
    btn_in[0] = 1'b0;
    step(8);

    // long press on channel 1
    long1_cnt = 0;
    rel1_cnt = 0;
    c0 = cyc;
    btn_in[1] = 1'b1;
    step(30);
    cmp("long_press_latency", 32'(press1_cyc - c0), 32'd6);
    cmp("long_pulse_offset", 32'(long1_cyc - press1_cyc), 32'd10);
    cmp("long_pulse_count", 32'(long1_cnt), 32'd1);
    btn_in[1] = 1'b0;
    step(8);
    cmp("long_release_count", 32'(rel1_cnt), 32'd1);
    cmp("long_no_second", 32'(long1_cnt), 32'd1);

    // toggle sequence from reset
    do_reset();
    rel0_cnt = 0;
    tgl_exp = 3'b101;
    for (int k = 0; k < 3; k++) begin
      btn_in[0] = 1'b1;
      step(7);
      cmp("toggle_seq", 32'(tgl[0]), 32'(tgl_exp[k]));
      btn_in[0] = 1'b0;
      step(7);
    end
    cmp("toggle_release_count", 32'(rel0_cnt), 32'd3);

    // reset while pressed and qualified
    btn_in[0] = 1'b1;
    step(7);
    cmp("midrst_level_before", 32'(lvl), 32'h1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("midrst_level_now", 32'(lvl), 32'd0);
    cmp("midrst_toggle_now", 32'(tgl), 32'd0);
    cmp("midrst_press_now", 32'(prs), 32'd0);
    step(1);
    rst_n = 1'b1;
    press0_cnt = 0;
    step(5);
    cmp("midrst_level_e4", 32'(lvl), 32'd0);
    step(1);
    cmp("midrst_level_e5", 32'(lvl), 32'h1);
    cmp("midrst_press_e5", 32'(prs), 32'h1);
    step(3);
    cmp("midrst_press_count", 32'(press0_cnt), 32'd1);
    btn_in = '0;
    step(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
